// File: rtl/my_nios_onchip_mem_arbiter_if.sv
// Bus bundle between the two Avalon-MM requesters, the arbiter and the on-chip memory.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface my_nios_onchip_mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int BE_W   = 4
);
  logic [ADDR_W-1:0] r0_address;
  logic [BE_W-1:0]   r0_byteenable;
  logic              r0_read;
  logic              r0_write;
  logic [DATA_W-1:0] r0_writedata;
  logic              r0_waitrequest;
  logic [DATA_W-1:0] r0_readdata;
  logic              r0_readdatavalid;

  logic [ADDR_W-1:0] r1_address;
  logic [BE_W-1:0]   r1_byteenable;
  logic              r1_read;
  logic              r1_write;
  logic [DATA_W-1:0] r1_writedata;
  logic              r1_waitrequest;
  logic [DATA_W-1:0] r1_readdata;
  logic              r1_readdatavalid;

  logic [ADDR_W-1:0] mem_address;
  logic [BE_W-1:0]   mem_byteenable;
  logic              mem_chipselect;
  logic              mem_write;
  logic [DATA_W-1:0] mem_writedata;
  logic              mem_clken;
  logic [DATA_W-1:0] mem_readdata;

  logic [1:0]        err_oor;

  modport slave (
    input  r0_address, r0_byteenable, r0_read, r0_write, r0_writedata,
    output r0_waitrequest, r0_readdata, r0_readdatavalid,
    input  r1_address, r1_byteenable, r1_read, r1_write, r1_writedata,
    output r1_waitrequest, r1_readdata, r1_readdatavalid,
    output mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken,
    input  mem_readdata,
    output err_oor
  );

  modport master (
    output r0_address, r0_byteenable, r0_read, r0_write, r0_writedata,
    input  r0_waitrequest, r0_readdata, r0_readdatavalid,
    output r1_address, r1_byteenable, r1_read, r1_write, r1_writedata,
    input  r1_waitrequest, r1_readdata, r1_readdatavalid,
    input  mem_address, mem_byteenable, mem_chipselect, mem_write, mem_writedata, mem_clken,
    output mem_readdata,
    input  err_oor
  );
endinterface

// File: rtl/my_nios_onchip_mem_arbiter.sv
// Shares one single-port on-chip memory between two Avalon-MM requesters, one access per cycle,
// with round-robin or fixed priority, tagged 1-cycle read return and out-of-range filtering.
module my_nios_onchip_mem_arbiter #(
  parameter int          ADDR_W         = 16,
  parameter int          DATA_W         = 32,
  parameter int          BE_W           = 4,
  parameter int unsigned DEPTH          = 51200,
  parameter bit          FIXED_PRIORITY = 1'b0
) (
  input logic clk,
  input logic reset,
  my_nios_onchip_mem_arbiter_if.slave bus
);

  logic              pend0;
  logic              pend1;
  logic              grant_valid;
  logic              grant_id;

  logic [ADDR_W-1:0] sel_addr;
  logic [BE_W-1:0]   sel_be;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_write;
  logic              sel_in_range;
  logic              mem_cs;

  logic              last_grant_q, last_grant_d;
  logic              rd_valid_q,   rd_valid_d;
  logic              rd_id_q,      rd_id_d;
  logic              rd_oor_q,     rd_oor_d;
  logic [1:0]        err_oor_q,    err_oor_d;

  logic              rd0_hit;
  logic              rd1_hit;

  // On a tie, round-robin hands the grant to whoever did not win last time.
  always_comb begin
    pend0       = bus.r0_read | bus.r0_write;
    pend1       = bus.r1_read | bus.r1_write;
    grant_valid = pend0 | pend1;
    if (pend0 && pend1) begin
      grant_id = FIXED_PRIORITY ? 1'b0 : ~last_grant_q;
    end else begin
      grant_id = pend1;
    end
  end

  always_comb begin
    if (grant_id) begin
      sel_addr  = bus.r1_address;
      sel_be    = bus.r1_byteenable;
      sel_wdata = bus.r1_writedata;
      sel_write = bus.r1_write;
    end else begin
      sel_addr  = bus.r0_address;
      sel_be    = bus.r0_byteenable;
      sel_wdata = bus.r0_writedata;
      sel_write = bus.r0_write;
    end
    sel_in_range = (32'(sel_addr) < DEPTH);
    mem_cs       = ~reset & grant_valid & sel_in_range;
  end

  always_comb begin
    bus.mem_address    = sel_addr;
    bus.mem_byteenable = sel_be;
    bus.mem_writedata  = sel_wdata;
    bus.mem_chipselect = mem_cs;
    bus.mem_write      = mem_cs & sel_write;
    bus.mem_clken      = ~reset;
    bus.r0_waitrequest = reset | (pend0 & grant_id);
    bus.r1_waitrequest = reset | (pend1 & ~grant_id);
    bus.err_oor        = err_oor_q;
  end

  // A read that was out of range still returns a beat, but with zero data.
  always_comb begin
    rd0_hit              = rd_valid_q & ~rd_id_q;
    rd1_hit              = rd_valid_q & rd_id_q;
    bus.r0_readdatavalid = rd0_hit;
    bus.r1_readdatavalid = rd1_hit;
    bus.r0_readdata      = (rd0_hit && !rd_oor_q) ? bus.mem_readdata : '0;
    bus.r1_readdata      = (rd1_hit && !rd_oor_q) ? bus.mem_readdata : '0;
  end

  always_comb begin
    last_grant_d = grant_valid ? grant_id : last_grant_q;
    rd_valid_d   = grant_valid & ~sel_write;
    rd_id_d      = grant_id;
    rd_oor_d     = ~sel_in_range;
    err_oor_d    = err_oor_q | ({grant_id, ~grant_id} & {2{grant_valid & ~sel_in_range}});
  end

  // last_grant resets to 1 so requester 0 wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= 1'b1;
      rd_valid_q   <= 1'b0;
      rd_id_q      <= 1'b0;
      rd_oor_q     <= 1'b0;
      err_oor_q    <= 2'b00;
    end else begin
      last_grant_q <= last_grant_d;
      rd_valid_q   <= rd_valid_d;
      rd_id_q      <= rd_id_d;
      rd_oor_q     <= rd_oor_d;
      err_oor_q    <= err_oor_d;
    end
  end

endmodule
